// File: rtl/fir_mac_pkg.sv
// fir_mac_pkg: shared types and helpers for the time-multiplexed FIR MAC engine.
//   state_t     : controller states IDLE / MAC / DONE
//   calc_acc_w  : full-precision accumulator width for a given configuration
//   sat_trunc   : clamps to the signed range of out_w bits when FIR_MAC_SAT_EN is
//                 defined; otherwise passes the value through so the caller's
//                 narrowing cast wraps it (two's complement).
package fir_mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Worst case |sum| is NUM_TAPS * 2**(DATA_W-1) * 2**(COEF_W-1), which always fits
  // in DATA_W+COEF_W+clog2(NUM_TAPS) signed bits.
  function automatic int calc_acc_w(input int data_w, input int coef_w, input int num_taps);
    return data_w + coef_w + $clog2(num_taps);
  endfunction

  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] val,
                                                  input int out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic               sat_en;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
`ifdef FIR_MAC_SAT_EN
    sat_en = 1'b1;
`else
    sat_en = 1'b0;
`endif
    if (sat_en && (val > hi)) return hi;
    if (sat_en && (val < lo)) return lo;
    return val;
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// fir_delay_line: sample shift register with indexed tap read.
//   iClk12M  : clock, rising edge
//   clr      : synchronous clear of every tap (dominates shift_en)
//   shift_en : shift din into tap 0, tap k takes tap k-1
//   din      : signed sample entering the line
//   tap_idx  : tap selected for reading
//   tap_data : combinational read of the selected tap
module fir_delay_line #(
  parameter int DATA_W   = 3,
  parameter int NUM_TAPS = 10,
  parameter int IDX_W    = $clog2(NUM_TAPS)
) (
  input  logic                     iClk12M,
  input  logic                     clr,
  input  logic                     shift_en,
  input  logic signed [DATA_W-1:0] din,
  input  logic        [IDX_W-1:0]  tap_idx,
  output logic signed [DATA_W-1:0] tap_data
);

  logic signed [DATA_W-1:0] taps [NUM_TAPS];

  always_ff @(posedge iClk12M) begin
    if (clr) begin
      for (int k = 0; k < NUM_TAPS; k++) taps[k] <= '0;
    end else if (shift_en) begin
      taps[0] <= din;
      for (int k = 1; k < NUM_TAPS; k++) taps[k] <= taps[k-1];
    end
  end

  assign tap_data = taps[tap_idx];

endmodule

// File: rtl/fir_mac_engine.sv
// fir_mac_engine: time-multiplexed FIR multiply-accumulate engine.
// Accepts one sample in IDLE, walks the taps one per cycle against an external
// synchronous coefficient memory, accumulates at full precision and presents the
// scaled result over a valid/ready handshake.
//   iClk12M    : clock, rising edge
//   iRst       : synchronous active-high reset
//   iInValid   : sample valid        iInData  : signed sample
//   oInReady   : high only in IDLE
//   oCoeffAddr : coefficient address (data returns on iCoeff the next cycle)
//   iCoeff     : signed coefficient for the previous cycle's address
//   oOutValid  : result valid, held until iOutReady
//   oOutData   : signed result       iOutReady : consumer accepts result
//   oBusy      : high in MAC or DONE
// Build option: FIR_MAC_SAT_EN defined -> output saturates instead of wrapping.
module fir_mac_engine
  import fir_mac_pkg::*;
#(
  parameter int DATA_W    = 3,
  parameter int COEF_W    = 16,
  parameter int NUM_TAPS  = 10,
  parameter int ADDR_W    = 5,
  parameter int OUT_W     = 16,
  parameter int OUT_SHIFT = 0
) (
  input  logic                     iClk12M,
  input  logic                     iRst,
  input  logic                     iInValid,
  input  logic signed [DATA_W-1:0] iInData,
  output logic                     oInReady,
  output logic        [ADDR_W-1:0] oCoeffAddr,
  input  logic signed [COEF_W-1:0] iCoeff,
  output logic                     oOutValid,
  output logic signed [OUT_W-1:0]  oOutData,
  input  logic                     iOutReady,
  output logic                     oBusy
);

  localparam int ACC_W  = calc_acc_w(DATA_W, COEF_W, NUM_TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int IDX_W  = $clog2(NUM_TAPS);
  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(NUM_TAPS - 1);

  function automatic logic signed [OUT_W-1:0] fmt_out(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] sh;
    sh = a >>> OUT_SHIFT;
    return OUT_W'(sat_trunc(64'(sh), OUT_W));
  endfunction

  state_t state, state_nx;

  logic        [ADDR_W-1:0] tap_cnt;
  logic                     issue_done;
  logic        [IDX_W-1:0]  tap_p0;
  logic                     vld_p0;
  logic signed [ACC_W-1:0]  acc_p1;
  logic signed [ACC_W-1:0]  acc_nx;
  logic signed [OUT_W-1:0]  out_data_p2;
  logic signed [DATA_W-1:0] tap_data;
  logic signed [PROD_W-1:0] prod;
  logic                     accept;

  assign accept = (state == IDLE) && iInValid;

  fir_delay_line #(
    .DATA_W  (DATA_W),
    .NUM_TAPS(NUM_TAPS),
    .IDX_W   (IDX_W)
  ) u_dly (
    .iClk12M (iClk12M),
    .clr     (iRst),
    .shift_en(accept),
    .din     (iInData),
    .tap_idx (tap_p0),
    .tap_data(tap_data)
  );

  always_ff @(posedge iClk12M) begin
    if (iRst) state <= IDLE;
    else      state <= state_nx;
  end

  // MAC ends after the drain cycle that follows the last issued address.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (iInValid)   state_nx = MAC;
      MAC:     if (issue_done) state_nx = DONE;
      DONE:    if (iOutReady)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Stage p0: address issue; tap index delayed to line up with iCoeff.
  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      tap_cnt    <= '0;
      issue_done <= 1'b0;
      tap_p0     <= '0;
      vld_p0     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tap_cnt    <= '0;
          issue_done <= 1'b0;
          vld_p0     <= 1'b0;
        end
        MAC: begin
          vld_p0 <= ~issue_done;
          tap_p0 <= tap_cnt[IDX_W-1:0];
          if (!issue_done) begin
            // Counter parks on the last tap so no out-of-range address is issued.
            if (tap_cnt == LAST_TAP) issue_done <= 1'b1;
            else                     tap_cnt    <= tap_cnt + ADDR_W'(1);
          end
        end
        default: vld_p0 <= 1'b0;
      endcase
    end
  end

  // Stage p1: multiply-accumulate with the coefficient returned this cycle.
  assign prod   = PROD_W'(tap_data) * PROD_W'(iCoeff);
  assign acc_nx = vld_p0 ? acc_p1 + ACC_W'(prod) : acc_p1;

  always_ff @(posedge iClk12M) begin
    if (iRst)        acc_p1 <= '0;
    else if (accept) acc_p1 <= '0;
    else if (state == MAC) acc_p1 <= acc_nx;
  end

  // Stage p2: result capture on DONE entry, including the final product.
  always_ff @(posedge iClk12M) begin
    if (iRst)                              out_data_p2 <= '0;
    else if ((state == MAC) && issue_done) out_data_p2 <= fmt_out(acc_nx);
  end

  assign oInReady   = (state == IDLE);
  assign oBusy      = (state == MAC) || (state == DONE);
  assign oOutValid  = (state == DONE);
  assign oCoeffAddr = (state == MAC) ? tap_cnt : '0;
  assign oOutData   = out_data_p2;

endmodule
